// File: rtl/ipg_req_scheduler.sv
// Round-robin scheduler for the PHY's single IPG request channel: paces issues,
// caps requests in flight, routes responses back by ID and flushes lost requests.
module ipg_req_scheduler #(
  parameter int DATA_WIDTH      = 64,
  parameter int NUM_REQ         = 4,
  parameter int ID_WIDTH        = 2,
  parameter int MIN_GAP         = 256,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_req_data,
  input  logic [NUM_REQ-1:0]            s_req_valid,
  output logic [NUM_REQ-1:0]            s_req_ready,
  output logic [DATA_WIDTH-1:0]         ipg_req_chunk,
  output logic                          reqq_write,
  input  logic [DATA_WIDTH-1:0]         ipg_rresp_chunk,
  output logic [DATA_WIDTH-1:0]         m_resp_data,
  output logic [NUM_REQ-1:0]            m_resp_valid,
  output logic [3:0]                    outstanding,
  output logic                          timeout
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = $clog2(MIN_GAP + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {OCC_IDLE, OCC_BUSY, OCC_FULL} occ_e;

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [3:0]            out_q, out_d;
  logic [DATA_WIDTH-1:0] prev_resp_q;
  logic [DATA_WIDTH-1:0] chunk_q, chunk_d;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
  logic [NUM_REQ-1:0]    mvalid_q, mvalid_d;
  logic                  timeout_q;

  occ_e                  occ;
  logic                  grant_found;
  logic [PW-1:0]         grant_idx;
  logic                  issue;
  logic                  resp_ev;
  logic                  expire;
  logic [ID_WIDTH-1:0]   resp_id;

  // Occupancy is a pure function of the in-flight count, so no separate state register.
  always_comb begin
    occ = OCC_BUSY;
    if (out_q == 4'd0)
      occ = OCC_IDLE;
    else if (out_q >= 4'(MAX_OUTSTANDING))
      occ = OCC_FULL;
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && s_req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = PW'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign issue   = enable && (gap_q == '0) && (occ != OCC_FULL) && grant_found;
  assign resp_id = ipg_rresp_chunk[DATA_WIDTH-1 -: ID_WIDTH];
  assign resp_ev = (ipg_rresp_chunk != '0) && (ipg_rresp_chunk != prev_resp_q);
  assign expire  = (occ != OCC_IDLE) && !resp_ev && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign s_req_ready[gi] = issue && (grant_idx == PW'(gi));
    assign mvalid_d[gi]    = resp_ev && (int'(resp_id) == gi);
  end

  always_comb begin
    ptr_d   = ptr_q;
    chunk_d = chunk_q;
    gap_d   = gap_q;
    mdata_d = mdata_q;
    out_d   = out_q;
    timer_d = timer_q + TW'(1);

    if (issue) begin
      chunk_d = s_req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      chunk_d[DATA_WIDTH-1 -: ID_WIDTH] = ID_WIDTH'(grant_idx);
      ptr_d   = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PW'(1);
      gap_d   = GW'(MIN_GAP - 1);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end

    if (resp_ev)
      mdata_d = ipg_rresp_chunk;

    // A flush discards everything in flight; a same-cycle issue survives it.
    if (expire)
      out_d = issue ? 4'd1 : 4'd0;
    else if (issue && !resp_ev)
      out_d = out_q + 4'd1;
    else if (resp_ev && !issue && out_q != 4'd0)
      out_d = out_q - 4'd1;

    if (resp_ev || expire || occ == OCC_IDLE)
      timer_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      gap_q       <= '0;
      timer_q     <= '0;
      out_q       <= '0;
      prev_resp_q <= '0;
      chunk_q     <= '0;
      write_q     <= 1'b0;
      mdata_q     <= '0;
      mvalid_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      gap_q       <= gap_d;
      timer_q     <= timer_d;
      out_q       <= out_d;
      prev_resp_q <= ipg_rresp_chunk;
      chunk_q     <= chunk_d;
      write_q     <= issue;
      mdata_q     <= mdata_d;
      mvalid_q    <= mvalid_d;
      timeout_q   <= expire;
    end
  end

  assign ipg_req_chunk = chunk_q;
  assign reqq_write    = write_q;
  assign m_resp_data   = mdata_q;
  assign m_resp_valid  = mvalid_q;
  assign outstanding   = out_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_ipg_req_scheduler.sv
// Bench for ipg_req_scheduler: vector table, directed corner sequences and a
// randomized run checked cycle by cycle against a timestamp-based reference model.
module tb_ipg_req_scheduler;

  localparam int DW   = 64;
  localparam int NR   = 4;
  localparam int GAP  = 4;
  localparam int MAXO = 2;
  localparam int TMO  = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic [NR*DW-1:0] s_req_data;
  logic [NR-1:0]  s_req_valid;
  logic [NR-1:0]  s_req_ready;
  logic [DW-1:0]  ipg_req_chunk;
  logic           reqq_write;
  logic [DW-1:0]  ipg_rresp_chunk;
  logic [DW-1:0]  m_resp_data;
  logic [NR-1:0]  m_resp_valid;
  logic [3:0]     outstanding;
  logic           timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ipg_req_scheduler #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(2), .MIN_GAP(GAP),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_req_data(s_req_data), .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .ipg_req_chunk(ipg_req_chunk), .reqq_write(reqq_write),
    .ipg_rresp_chunk(ipg_rresp_chunk), .m_resp_data(m_resp_data),
    .m_resp_valid(m_resp_valid), .outstanding(outstanding), .timeout(timeout)
  );

  // Reference model: issues are paced by the timestamp of the last issue, and the
  // watchdog by the timestamp at which it was last cleared.
  int          m_cyc = 0;
  int          m_last = -100000;
  int          m_start = 0;
  int          m_out = 0;
  int          m_clear = 0;
  logic [63:0] m_prev = '0;
  logic [63:0] e_chunk = '0, e_mdata = '0;
  logic [3:0]  e_mvalid = '0;
  logic        e_reqq = 1'b0, e_tmo = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  task automatic tick();
    bit can, rev, exp_tmo;
    int g, id, old_out;
    logic [3:0] exp_ready;
    logic [63:0] d;
    #1;
    can = enable && (m_cyc - m_last >= GAP) && (m_out < MAXO) && (s_req_valid != 0);
    g = 0;
    for (int k = NR - 1; k >= 0; k--)
      if (s_req_valid[(m_start + k) % NR]) g = (m_start + k) % NR;
    exp_ready = can ? 4'(1 << g) : 4'b0;
    chk("ready", 64'(s_req_ready), 64'(exp_ready));
    rev = (ipg_rresp_chunk != 0) && (ipg_rresp_chunk != m_prev);
    exp_tmo = (m_out > 0) && !rev && (m_cyc - m_clear == TMO - 1);
    old_out = m_out;
    if (rst) begin
      e_chunk = '0; e_mdata = '0; e_mvalid = '0; e_reqq = 0; e_tmo = 0;
      m_out = 0; m_start = 0; m_prev = '0; m_last = -100000; m_clear = m_cyc + 1;
    end else begin
      e_reqq = can;
      if (can) begin
        d = s_req_data[g*DW +: DW];
        e_chunk = (d & 64'h3FFF_FFFF_FFFF_FFFF) | (64'(g) << 62);
        m_last = m_cyc;
        m_start = (g + 1) % NR;
      end
      e_mvalid = '0;
      if (rev) begin
        e_mdata = ipg_rresp_chunk;
        id = int'(ipg_rresp_chunk >> 62);
        if (id < NR) e_mvalid = 4'(1 << id);
      end
      m_prev = ipg_rresp_chunk;
      if (exp_tmo) m_out = can ? 1 : 0;
      else if (can && !rev) m_out = m_out + 1;
      else if (rev && !can && m_out > 0) m_out = m_out - 1;
      e_tmo = exp_tmo;
      if (rev || exp_tmo || old_out == 0) m_clear = m_cyc + 1;
    end
    m_cyc++;
    @(posedge clk);
    #1;
    chk("reqq_write", 64'(reqq_write), 64'(e_reqq));
    chk("ipg_req_chunk", ipg_req_chunk, e_chunk);
    chk("m_resp_data", m_resp_data, e_mdata);
    chk("m_resp_valid", 64'(m_resp_valid), 64'(e_mvalid));
    chk("outstanding", 64'(outstanding), 64'(m_out));
    chk("timeout", 64'(timeout), 64'(e_tmo));
    if (reqq_write === 1'b1)
      $display("xfer id=%0d chunk=%h outstanding=%0d", ipg_req_chunk[63:62], ipg_req_chunk, outstanding);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; enable = 0; s_req_valid = '0; ipg_rresp_chunk = '0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic default_data();
    for (int i = 0; i < NR; i++)
      s_req_data[i*DW +: DW] = 64'hFF00_0000_0000_0000 | (64'hAA + 64'(i));
  endtask

  typedef struct {
    bit          en;
    logic [3:0]  valid;
    logic [63:0] resp;
    logic [3:0]  ready;
    int          out;
    logic [3:0]  mvalid;
    bit          reqq;
  } vec_t;

  vec_t tbl[20];
  int   ids[$];
  int   times[$];

  initial begin
    int cnt, first;
    logic [63:0] r0, r1, r1b;
    r0 = 64'h1; r1 = 64'h4000_0000_0000_0002; r1b = 64'h4000_0000_0000_0001;
    tbl[0]  = '{1, 4'b1111, 64'h0, 4'b0001, 1, 4'b0000, 1};
    tbl[1]  = '{1, 4'b1111, 64'h0, 4'b0000, 1, 4'b0000, 0};
    tbl[2]  = '{1, 4'b1111, r0,    4'b0000, 0, 4'b0001, 0};
    tbl[3]  = '{1, 4'b1111, r0,    4'b0000, 0, 4'b0000, 0};
    tbl[4]  = '{1, 4'b1111, r0,    4'b0010, 1, 4'b0000, 1};
    tbl[5]  = '{1, 4'b1111, r1,    4'b0000, 0, 4'b0010, 0};
    tbl[6]  = '{1, 4'b1111, r1,    4'b0000, 0, 4'b0000, 0};
    tbl[7]  = '{1, 4'b1111, 64'h0, 4'b0000, 0, 4'b0000, 0};
    tbl[8]  = '{1, 4'b0101, 64'h0, 4'b0100, 1, 4'b0000, 1};
    tbl[9]  = '{1, 4'b0101, 64'h0, 4'b0000, 1, 4'b0000, 0};
    tbl[10] = '{1, 4'b0101, 64'h0, 4'b0000, 1, 4'b0000, 0};
    tbl[11] = '{1, 4'b0101, 64'h0, 4'b0000, 1, 4'b0000, 0};
    tbl[12] = '{1, 4'b0001, 64'h0, 4'b0001, 2, 4'b0000, 1};
    tbl[13] = '{1, 4'b1111, 64'h0, 4'b0000, 2, 4'b0000, 0};
    tbl[14] = '{1, 4'b1111, 64'h0, 4'b0000, 2, 4'b0000, 0};
    tbl[15] = '{1, 4'b1111, 64'h0, 4'b0000, 2, 4'b0000, 0};
    tbl[16] = '{1, 4'b1111, 64'h0, 4'b0000, 2, 4'b0000, 0};
    tbl[17] = '{0, 4'b1111, r1b,   4'b0000, 1, 4'b0010, 0};
    tbl[18] = '{0, 4'b1111, r1b,   4'b0000, 1, 4'b0000, 0};
    tbl[19] = '{1, 4'b1111, r1b,   4'b0010, 2, 4'b0000, 1};

    default_data();
    @(negedge clk);
    do_reset();
    chk("reset_outstanding", 64'(outstanding), 64'h0);
    chk("reset_chunk", ipg_req_chunk, 64'h0);

    // Vector table: rotation, pacing, FULL blocking, enable low, response routing.
    for (int i = 0; i < 20; i++) begin
      enable = tbl[i].en; s_req_valid = tbl[i].valid; ipg_rresp_chunk = tbl[i].resp;
      #1 chk($sformatf("tbl%0d_ready", i), 64'(s_req_ready), 64'(tbl[i].ready));
      tick();
      chk($sformatf("tbl%0d_out", i), 64'(outstanding), 64'(tbl[i].out));
      chk($sformatf("tbl%0d_mvalid", i), 64'(m_resp_valid), 64'(tbl[i].mvalid));
      chk($sformatf("tbl%0d_reqq", i), 64'(reqq_write), 64'(tbl[i].reqq));
    end

    // All four valid, each issue answered: grants 0,1,2,3,0 spaced GAP apart.
    do_reset();
    enable = 1; s_req_valid = 4'b1111;
    for (int t = 0; t < 21; t++) begin
      tick();
      ipg_rresp_chunk = '0;
      if (reqq_write === 1'b1) begin
        ids.push_back(int'(ipg_req_chunk[63:62]));
        times.push_back(t);
        ipg_rresp_chunk = ipg_req_chunk;
      end
    end
    chk("rr_count", 64'(ids.size() >= 5), 64'h1);
    for (int i = 0; i < 5 && i < ids.size(); i++) begin
      chk($sformatf("rr_id%0d", i), 64'(ids[i]), 64'(i % NR));
      if (i > 0) chk($sformatf("rr_space%0d", i), 64'(times[i] - times[i-1]), 64'(GAP));
    end

    // A response held for 10 cycles is forwarded once; issue+response keeps the count.
    do_reset();
    enable = 1; s_req_valid = 4'b0001;
    tick();
    s_req_valid = '0; ipg_rresp_chunk = 64'h5;
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (m_resp_valid != 0) cnt++;
    end
    chk("held_pulses", 64'(cnt), 64'd1);
    chk("held_out", 64'(outstanding), 64'd0);
    s_req_valid = 4'b0001;
    tick();
    s_req_valid = '0;
    tick(); tick(); tick();
    s_req_valid = 4'b0001; ipg_rresp_chunk = 64'h6;
    tick();
    chk("simul_out", 64'(outstanding), 64'd1);
    chk("simul_reqq", 64'(reqq_write), 64'd1);
    chk("simul_mvalid", 64'(m_resp_valid), 64'b0001);

    // One issue with no response: flush 16 cycles after the write strobe.
    s_req_data[0 +: DW] = 64'hAA;
    do_reset();
    enable = 1; s_req_valid = 4'b0001;
    tick();
    chk("single_chunk", ipg_req_chunk, 64'hAA);
    s_req_valid = '0;
    first = -1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (timeout === 1'b1 && first < 0) first = k;
      if (k == 16) chk("tmo_out", 64'(outstanding), 64'd0);
    end
    chk("tmo_cycle", 64'(first), 64'd16);

    // Response on the expiry cycle wins over the flush.
    do_reset();
    enable = 1; s_req_valid = 4'b0001;
    tick();
    s_req_valid = '0;
    for (int k = 1; k <= 15; k++) tick();
    ipg_rresp_chunk = 64'h7;
    tick();
    chk("race_timeout", 64'(timeout), 64'd0);
    chk("race_out", 64'(outstanding), 64'd0);
    chk("race_mvalid", 64'(m_resp_valid), 64'b0001);
    tick(); tick();
    default_data();

    // Reset on a grant cycle cancels the transfer and restarts rotation at 0.
    do_reset();
    enable = 1; s_req_valid = 4'b1111;
    tick();
    s_req_valid = '0;
    tick(); tick(); tick();
    s_req_valid = 4'b1111; rst = 1;
    #1 chk("rst_grant_ready", 64'(s_req_ready), 64'b0010);
    tick();
    chk("rst_reqq", 64'(reqq_write), 64'd0);
    chk("rst_out", 64'(outstanding), 64'd0);
    rst = 0;
    #1 chk("rst_next_ready", 64'(s_req_ready), 64'b0001);
    tick();
    chk("rst_next_id", 64'(ipg_req_chunk[63:62]), 64'd0);

    // Randomized run against the reference model.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      int r;
      rst = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 9) != 0);
      s_req_valid = 4'($urandom);
      if ($urandom_range(0, 15) == 0)
        for (int i = 0; i < NR * 2; i++) s_req_data[i*32 +: 32] = $urandom;
      r = $urandom_range(0, 39);
      if (r == 0) ipg_rresp_chunk = {$urandom, $urandom};
      else if (r == 1) ipg_rresp_chunk = '0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
